// File: rtl/seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scan
// Description : Time-multiplexed hex display driver. A prescaler sets the slot
//               length per digit, and the scan index walks the digits. New data
//               is double-buffered so that it only takes effect at a frame
//               boundary. Segment and anode outputs are active-low and
//               registered.
//               Optional macro SEVEN_SEGMENT_LZB_EN: leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESCALE - 1);
    localparam logic [c_IW-1:0] c_IMAX = c_IW'(NUM_DIGITS - 1);

    logic [c_PW-1:0]         r_presc;
    logic [c_IW-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_blank;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_nib;
    logic                    w_blank_sel;
    logic [NUM_DIGITS-1:0]   w_an_n;

    assign w_tick = (r_presc == c_PMAX);
    assign w_wrap = w_tick && (r_idx == c_IMAX);

    // Active-low hex decode, abcdefg with bit 6 = segment a
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0001100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

`ifdef SEVEN_SEGMENT_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always stays lit so a zero value still shows "0".
    logic [NUM_DIGITS-1:0] w_lzb;
    assign w_lzb[0] = 1'b0;
    if (NUM_DIGITS > 1) begin : g_lzb_multi
        for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lzb_bit
            assign w_lzb[g] = ~|r_disp_val[4*NUM_DIGITS-1:4*g];
        end
    end
    assign w_blank = r_disp_blank | w_lzb;
`else
    assign w_blank = r_disp_blank;
`endif

    // Select the nibble, blank flag and anode pattern for the current index
    always_comb begin
        w_nib       = 4'h0;
        w_blank_sel = 1'b0;
        w_an_n      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_nib       = r_disp_val[4*i +: 4];
                w_blank_sel = w_blank[i];
                w_an_n[i]   = 1'b0;
            end
        end
    end

    // Prescaler, digit index and the frame-wrap pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Double buffer: loads land in pending; display swaps only at the wrap,
    // and a load on the wrap tick bypasses pending so the newest data wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_val   <= '0;
            r_pend_blank <= '0;
            r_disp_val   <= '0;
            r_disp_blank <= '0;
        end else begin
            if (load) begin
                r_pend_val   <= value;
                r_pend_blank <= blank_mask;
            end
            if (w_wrap) begin
                r_disp_val   <= load ? value      : r_pend_val;
                r_disp_blank <= load ? blank_mask : r_pend_blank;
            end
        end
    end

    // Registered active-low outputs, one cycle behind the index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= w_an_n;
            r_seg <= w_blank_sel ? 7'b1111111 : f_decode(w_nib);
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_scan
// Description : Directed self-checking bench for seven_segment_scan with
//               NUM_DIGITS=4, PRESCALE=4 (16-cycle frames). Honours
//               SEVEN_SEGMENT_LZB_EN for the leading-zero expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan;

    localparam int ND = 4;
    localparam int PS = 4;

`ifdef SEVEN_SEGMENT_LZB_EN
    localparam logic [6:0] Z_HI = 7'b1111111;
`else
    localparam logic [6:0] Z_HI = 7'b0000001;
`endif
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] SB = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = 16'h0;
    logic [3:0]    blank_mask = 4'h0;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          frame_done;

    int n_total = 0;
    int n_bad   = 0;

    seven_segment_scan #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Step negedges until frame_done is seen (bounded)
    task automatic wait_frame();
        int k = 0;
        while (!frame_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait", {31'b0, frame_done}, 32'd1);
    endtask

    // Check one full frame of 16 cycles; optionally issue up to two loads at
    // given cycles (load set at negedge of cycle c is captured on edge c+1).
    task automatic frame(input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3,
                         input int la, input logic [15:0] va, input logic [3:0] ma,
                         input int lb, input logic [15:0] vb, input logic [3:0] mb);
        logic [6:0] e [4];
        logic [3:0] ea;
        int d;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        wait_frame();
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c == la) begin load = 1'b1; value = va; blank_mask = ma; end
            if (c == lb) begin load = 1'b1; value = vb; blank_mask = mb; end
            d  = (c - 1) / 4;
            ea = ~(4'b0001 << d);
            check($sformatf("an c%0d", c), {28'b0, an}, {28'b0, ea});
            check($sformatf("seg c%0d", c), {25'b0, seg}, {25'b0, e[d]});
        end
        load = 1'b0;
    endtask

    // Free-running scan from a fresh reset, all digits showing zero
    task automatic scan_from_reset(input int cycles);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        int d;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            d  = ((c - 1) / 4) % 4;
            ea = ~(4'b0001 << d);
            es = (d == 0) ? S0 : Z_HI;
            ef = ((c % 16) == 0);
            check($sformatf("scan an c%0d", c), {28'b0, an}, {28'b0, ea});
            check($sformatf("scan seg c%0d", c), {25'b0, seg}, {25'b0, es});
            check($sformatf("scan fd c%0d", c), {31'b0, frame_done}, {31'b0, ef});
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst an", {28'b0, an}, 32'hF);
        check("rst seg", {25'b0, seg}, 32'h7F);
        check("rst fd", {31'b0, frame_done}, 32'd0);
        rst = 1'b0;

        // Scan sequence, latency and frame_done period over two frames
        scan_from_reset(32);

        // Mid-frame load of 0x3A7F: current frame unchanged
        frame(S0, Z_HI, Z_HI, Z_HI, 5, 16'h3A7F, 4'h0, 0, 16'h0, 4'h0);
        // Decoded 0x3A7F; last-wins loads 0x1111 then 0x2222
        frame(SF, S7, SA, S3, 2, 16'h1111, 4'h0, 9, 16'h2222, 4'h0);
        // All twos; load 0x5555 coinciding with the wrap tick
        frame(S2, S2, S2, S2, 15, 16'h5555, 4'h0, 0, 16'h0, 4'h0);
        // All fives; load 0x1234 with blank_mask 1010
        frame(S5, S5, S5, S5, 3, 16'h1234, 4'b1010, 0, 16'h0, 4'h0);
        // Digits 1 and 3 blanked while anodes keep strobing; load 0x0040
        frame(S4, SB, S2, SB, 3, 16'h0040, 4'h0, 0, 16'h0, 4'h0);
        // 0x0040: leading zeros dark only with blanking enabled
        frame(S0, S4, Z_HI, Z_HI, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

        // Mid-frame reset at index 2 with a pending load that must be lost
        wait_frame();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            load = (c == 2);
            if (c == 2) value = 16'h8888;
        end
        load = 1'b0;
        check("pre-rst an", {28'b0, an}, 32'hB);
        #1 rst = 1'b1;
        #1;
        check("async rst an", {28'b0, an}, 32'hF);
        check("async rst seg", {25'b0, seg}, 32'h7F);
        check("async rst fd", {31'b0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        scan_from_reset(16);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter PRESCALE, default 50000, meaning clk cycles per digit slot (legal minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: a high sample captures value and blank_mask.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS bits: one hex nibble per digit, with digit 0 at bits [3:0].
REQ-007 SHALL have port blank_mask, input, NUM_DIGITS bits: a 1 forces that digit dark.
REQ-008 SHALL have port seg, output, 7 bits: segments in abcdefg order (bit 6 = a), active-low, registered.
REQ-009 SHALL have port an, output, NUM_DIGITS bits: active-low digit enables, at most one low, registered.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the scan wraps to digit 0.

Function
REQ-011 SHALL run a prescaler counting 0..PRESCALE-1; it wraps to 0 and raises an internal tick for the cycle in which it equals PRESCALE-1.
REQ-012 SHALL increment a digit index on each tick, wrapping from NUM_DIGITS-1 to 0; with NUM_DIGITS=1 the index stays at 0 and every tick is a wrap.
REQ-013 SHALL drive frame_done high for exactly the one cycle after the tick that wraps the index to 0.
REQ-014 SHALL capture value and blank_mask into a pending register when load is high; if several loads occur in one frame, the last one wins.
REQ-015 SHALL copy the pending register to the display register on the wrapping tick, so that no frame shows mixed old and new data.
REQ-016 SHALL, when load coincides with the wrapping tick, copy the input value directly to the display register on that tick, with input taking precedence over pending.
REQ-017 SHALL register an and seg each cycle from the current index and display register, giving one cycle of latency from an index change to the outputs.
REQ-018 SHALL drive an low only at the bit equal to the index.
REQ-019 SHALL decode the selected nibble active-low, abcdefg order, as follows: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0001100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-020 SHALL drive seg to 1111111 when the digit is blanked, while still driving that digit's an bit low.
REQ-021 SHALL leave seg and an unchanged while load toggles mid-frame; changes become visible only after the next wrap.

Reset
REQ-022 SHALL, while rst is high, hold the prescaler at 0, index at 0, pending and display registers at 0, blank masks at all 0, an at all ones, seg at 1111111, and frame_done at 0.
REQ-023 SHALL, on the first rising edge after rst falls, drive an=~1 (digit 0) and seg=0000001.
REQ-024 SHALL restore the reset state immediately on rst assertion mid-frame, discarding any pending load.

Configuration
REQ-025 SHALL, when the macro SEVEN_SEGMENT_LZB_EN is defined, also blank every digit above the highest nonzero nibble of the display value (leading-zero blanking), with digit 0 never auto-blanked.
REQ-026 SHALL, when SEVEN_SEGMENT_LZB_EN is undefined, apply only blank_mask, and all leading-zero logic SHALL be absent.

Verification
REQ-027 SHALL verify reset and scan: NUM_DIGITS=4, PRESCALE=4, rst released -> an sequence 1110,1101,1011,0111 each held 4 cycles, seg=0000001, and frame_done pulsing every 16 cycles.
REQ-028 SHALL verify decode: load value=0x3A7F mid-frame -> display unchanged until wrap, then digits 0..3 show 0111000, 0001111, 0001000, 0000110.
REQ-029 SHALL verify last-wins and coincidence: load 0x1111 then 0x2222 within one frame -> next frame shows 2 on all digits; load 0x5555 on the wrap tick -> that frame shows 0100100.
REQ-030 SHALL verify blanking: blank_mask=1010 -> digits 1 and 3 give seg=1111111 with an still strobing.
REQ-031 SHALL verify the macro: with SEVEN_SEGMENT_LZB_EN defined, value=0x0040 -> digits 3 and 2 blank, digit 1 shows 1001100, digit 0 shows 0000001; with the macro undefined, all four digits are lit.
REQ-032 SHALL verify mid-frame reset: rst pulsed at index 2 -> an=1111 and seg=1111111 asynchronously, then scanning resumes from digit 0 with display value 0.
